uart_rx_monitor: RTL
====================

UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 32, meaning clk cycles per UART bit (25 MHz / 781250 baud); legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY_MODE, default 0, meaning parity setting: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits checked; legal values 1..2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning receive buffer entries; power of two, 2..256.
REQ-006 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port data_o, output, 8 bits: head character, zero-extended above DATA_BITS.
REQ-010 SHALL have port perr_o, output, 1 bit: parity error flag of the head entry.
REQ-011 SHALL have port ferr_o, output, 1 bit: framing error flag of the head entry.
REQ-012 SHALL have port valid_o, output, 1 bit: the FIFO is non-empty.
REQ-013 SHALL have port ready_i, input, 1 bit: the consumer pops the head entry on valid_o && ready_i.
REQ-014 SHALL have port ovf_o, output, 1 bit: sticky overflow flag.
REQ-015 SHALL have port clr_ovf_i, input, 1 bit: clears ovf_o.
REQ-016 SHALL have port count_o, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-017 SHALL have port busy_o, output, 1 bit: the receive FSM is not in IDLE.
REQ-018 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-019 SHALL pass rx_i through a two-flop synchronizer, reset value 1; all references to rx below mean the synchronized rx.
REQ-020 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 SHALL go from IDLE to START on the first cycle a falling edge of rx is seen (previous sample 1, current 0), and load the bit counter with CLKS_PER_BIT/2-1.
REQ-022 SHALL, at the START mid-bit sample, go to DATA if rx=0; if rx=1 it is a glitch and the FSM SHALL return to IDLE with no push.
REQ-023 SHALL sample each DATA bit once, CLKS_PER_BIT cycles after the previous sample, LSB first, DATA_BITS samples in total.
REQ-024 SHALL, when PARITY_MODE!=0, take one PARITY sample; perr SHALL be set when (XOR of the data bits XOR the parity bit) != (PARITY_MODE==2).
REQ-025 SHALL take STOP_BITS stop samples; ferr SHALL be set if any stop sample is 0.
REQ-026 SHALL push {ferr, perr, data} in the cycle after the last stop sample, then return to IDLE.
REQ-027 SHALL, after a frame with ferr set, re-arm only after rx has been sampled high, so that a break condition produces exactly one entry.
REQ-028 SHALL make the first-bit timing such that the latency from the rx_i falling edge to valid_o rising is 2 (sync) + 1 + CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS-0.5) + 1 cycles, ±1, where P=1 if parity is enabled.
REQ-029 SHALL implement the FIFO as a circular buffer with wrapping read/write pointers; data_o, perr_o and ferr_o SHALL be driven combinationally from the head entry.
REQ-030 SHALL, on a push while full without a same-cycle pop, drop the new entry and set ovf_o in the next cycle.
REQ-031 SHALL, on a push and pop in the same cycle, accept both, including when full or empty; count_o is then unchanged.
REQ-032 SHALL have no effect for a pop while empty.
REQ-033 SHALL keep ovf_o high if clr_ovf_i and a new overflow occur in the same cycle (set wins).

Reset
REQ-034 SHALL, on rst, put the FSM in IDLE, empty the FIFO and clear the pointers, drive valid_o=0, ovf_o=0, count_o=0 and busy_o=0, and set the synchronizer to 1; data_o is don't-care while valid_o=0.
REQ-035 SHALL, on rst in the middle of a frame, discard the partial frame, and SHALL NOT start a new frame until a new falling edge is seen after reset is released.

Structure
REQ-036 SHALL place the parity-mode enum (PAR_NONE, PAR_EVEN, PAR_ODD), the FSM state typedef and the entry struct {ferr, perr, data[7:0]} in the package uart_mon_pkg.
REQ-037 SHALL implement the FIFO as one sub-module, uart_mon_fifo, parametrised by DEPTH and entry width.

Verification
REQ-038 SHALL cover, with defaults: send 0x65 8N1 with ready_i=1 -> one pop, data_o=0x65, perr_o=0, ferr_o=0, latency per REQ-028.
REQ-039 SHALL cover, with PARITY_MODE=1: send 0x07 with a wrong parity bit -> data_o=0x07, perr_o=1; the same byte with correct parity -> perr_o=0.
REQ-040 SHALL cover: hold rx_i low for 20 bit times -> exactly one entry, data_o=0x00, ferr_o=1; no further entries until rx_i returns high.
REQ-041 SHALL cover: a 0-pulse of CLKS_PER_BIT/4 cycles on idle rx_i -> no push, busy_o returns to 0.
REQ-042 SHALL cover, with FIFO_DEPTH=4 and ready_i=0: send 5 bytes 0x01..0x05 -> count_o=4, ovf_o=1, pops return 0x01..0x04; clr_ovf_i clears ovf_o.
REQ-043 SHALL cover: assert rst in the middle of a frame -> valid_o=0, count_o=0; the next complete frame 0xA5 is received correctly.

Source files
------------

// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the UART receive monitor.
package uart_mon_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  // Unused upper data bits are zero, so reducing the full byte is safe.
  function automatic logic parity_error(input logic [7:0] data, input logic par_bit,
                                        input logic odd);
    return (((^data) ^ par_bit) != odd);
  endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// Circular receive buffer with sticky overflow flag; head is read combinationally.
module uart_mon_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             ovf_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic             ovf_set_s;

  // Qualify requests: a pop on empty is ignored, a push on full only lands with a same-cycle pop.
  always_comb begin
    full_s    = (count_r == FULL_COUNT);
    empty_s   = (count_r == {CW{1'b0}});
    do_pop_s  = pop & ~empty_s;
    do_push_s = push & (~full_s | do_pop_s);
    ovf_set_s = push & full_s & ~do_pop_s;
  end

  // Pointer, occupancy and overflow bookkeeping; overflow set has priority over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = empty_s;
  assign ovf   = ovf_r;

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receiver with mid-bit sampling, parity/framing checks and a receive FIFO.
module uart_rx_monitor
  import uart_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 32,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  output logic [7:0]                    data_o,
  output logic                          perr_o,
  output logic                          ferr_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          ovf_o,
  input  logic                          clr_ovf_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          busy_o
);

  localparam parity_mode_e PAR_CFG     = parity_mode_e'(PARITY_MODE[1:0]);
  localparam logic         PAR_EN      = (PAR_CFG != PAR_NONE);
  localparam logic         PAR_ODD_CFG = (PAR_CFG == PAR_ODD);
  localparam logic [15:0]  HALF_CNT    = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]  FULL_CNT    = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]   LAST_DATA   = 3'(DATA_BITS - 1);
  localparam logic [2:0]   LAST_STOP   = 3'(STOP_BITS - 1);

  logic       rx_meta_r;
  logic       rx_sync_r;
  logic       rx_prev_r;
  logic       meta_vld_r;
  logic       sync_vld_r;
  logic       prev_vld_r;
  logic       fall_s;
  rx_state_e  state_r;
  logic [15:0] cnt_r;
  logic [2:0] bit_idx_r;
  logic [7:0] data_r;
  logic       perr_r;
  logic       ferr_r;
  logic       push_r;
  logic       busy_r;
  rx_entry_t  entry_s;
  rx_entry_t  head_s;
  logic       empty_s;
  logic       pop_s;

  // Two-flop synchronizer plus edge-history flop; the *_vld chain marks samples
  // that came from the line rather than from reset, so a line held low through
  // reset is not mistaken for a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      meta_vld_r <= 1'b0;
      sync_vld_r <= 1'b0;
      prev_vld_r <= 1'b0;
    end else begin
      rx_meta_r  <= rx_i;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      meta_vld_r <= 1'b1;
      sync_vld_r <= meta_vld_r;
      prev_vld_r <= sync_vld_r;
    end
  end

  // Start-edge detect, entry packing and consumer pop qualification.
  always_comb begin
    fall_s       = prev_vld_r & rx_prev_r & ~rx_sync_r;
    entry_s.ferr = ferr_r;
    entry_s.perr = perr_r;
    entry_s.data = data_r;
    pop_s        = ready_i & ~empty_s;
  end

  // Receive FSM. Only a falling edge leaves IDLE, so after a break frame the
  // line must return high before another frame can start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
      data_r    <= 8'd0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      push_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      push_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            state_r <= START;
            busy_r  <= 1'b1;
            cnt_r   <= HALF_CNT;
          end
        end
        START: begin
          if (cnt_r != 16'd0) begin
            cnt_r <= cnt_r - 16'd1;
          end else if (rx_sync_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r   <= DATA;
            cnt_r     <= FULL_CNT;
            bit_idx_r <= 3'd0;
            data_r    <= 8'd0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
          end
        end
        DATA: begin
          if (cnt_r != 16'd0) begin
            cnt_r <= cnt_r - 16'd1;
          end else begin
            data_r[bit_idx_r] <= rx_sync_r;
            cnt_r             <= FULL_CNT;
            if (bit_idx_r == LAST_DATA) begin
              bit_idx_r <= 3'd0;
              state_r   <= PAR_EN ? PARITY : STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
        PARITY: begin
          if (cnt_r != 16'd0) begin
            cnt_r <= cnt_r - 16'd1;
          end else begin
            perr_r  <= parity_error(data_r, rx_sync_r, PAR_ODD_CFG);
            cnt_r   <= FULL_CNT;
            state_r <= STOP;
          end
        end
        STOP: begin
          if (cnt_r != 16'd0) begin
            cnt_r <= cnt_r - 16'd1;
          end else begin
            ferr_r <= ferr_r | ~rx_sync_r;
            if (bit_idx_r == LAST_STOP) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              push_r  <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              cnt_r     <= FULL_CNT;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  uart_mon_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rx_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_r),
    .push_data (entry_s),
    .pop       (pop_s),
    .clr_ovf   (clr_ovf_i),
    .head      (head_s),
    .count     (count_o),
    .empty     (empty_s),
    .ovf       (ovf_o)
  );

  assign data_o  = head_s.data;
  assign perr_o  = head_s.perr;
  assign ferr_o  = head_s.ferr;
  assign valid_o = ~empty_s;
  assign busy_o  = busy_r;

endmodule
